jogador_automatico: RTL
=======================

# jogador_automatico

Hardware auto-player for the memory game: the sending end of the `jogar`/`botoes` interface that the game circuit receives. It sits beside the game core on the FPGA and replaces the human player for self-test. It starts a game, then replays the expected one-hot button sequence round by round with fixed hold and release times. It finishes when it sees `ganhou` or `perdeu`, or when a timeout expires.

## Interface
Parameters:
- `JOGAR_CICLOS`, 5: cycles `jogar` is held high at game start.
- `HOLD`, 10: cycles each button press is held.
- `GAP`, 10: cycles of `botoes=0` after each press; also the delay after `jogar` drops.
- `RODADAS`, 16: rounds to play (1..16). Round r plays presses 0..r-1.
- `TMO`, 5000: cycles to wait for `ganhou`/`perdeu` after the last press.

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: **asynchronous, active-low** reset.
- `iniciar` in 1: start request; level, sampled on rising edge.
- `ganhou` in 1: win indication from the game core.
- `perdeu` in 1: loss indication from the game core.
- `jogar` out 1: game start pulse to the core.
- `botoes` out 4: one-hot button presses to the core.
- `ocupado` out 1: high in every state except OCIOSO and FIM.
- `fim` out 1: high in FIM.
- `sucesso` out 1: valid while `fim`=1. 1 means `ganhou` was seen.
- `timeout` out 1: valid while `fim`=1. 1 means TMO expired.
- `db_estado` out 4: state code.
- `db_rodada` out 4: current round minus 1.

## Operation
- Sequence ROM: entry j is `4'b0001 << (j mod 4)`, giving 0001, 0010, 0100, 1000, 0001, ...
- Counters:
  - round counter r, 1..RODADAS.
  - press index j, 0..r-1.
  - timer, wide enough for max(HOLD, GAP, JOGAR_CICLOS, TMO).
- States and codes:
  - OCIOSO (0): all outputs 0. On `iniciar` go to INICIA.
  - INICIA (1): `jogar`=1 for JOGAR_CICLOS cycles, then ESPERA.
  - ESPERA (2): idle GAP cycles. Set r=1, j=0, then PRESSIONA.
  - PRESSIONA (3): `botoes`=ROM[j] for HOLD cycles, then SOLTA.
  - SOLTA (4): `botoes`=0 for GAP cycles.
    - If j<r-1: j++ and go to PRESSIONA.
    - Else if r<RODADAS: go to PROX.
    - Else: go to AGUARDA.
  - PROX (5): one cycle. r++, j=0, then PRESSIONA.
  - AGUARDA (6): wait up to TMO cycles. On expiry go to FIM with `timeout`=1, `sucesso`=0.
  - FIM (7): hold result. On `iniciar` go to INICIA and clear `sucesso`/`timeout`.
- Result monitoring applies in INICIA through AGUARDA:
  - `perdeu`=1 goes to FIM with `sucesso`=0.
  - `ganhou`=1 goes to FIM with `sucesso`=1.
  - If both are high in the same cycle, `perdeu` wins.
  - `botoes` and `jogar` are 0 from the first FIM cycle.
- `iniciar` is ignored while `ocupado`=1.

## Timing
- All outputs are registered.
- Reset value of every output is 0. The state returns to OCIOSO immediately on `reset`=0, including mid-press.
- Start: `iniciar` is sampled high at edge k. `jogar` is 1 during cycles k+1 .. k+JOGAR_CICLOS, and `botoes` first goes nonzero at cycle k+JOGAR_CICLOS+GAP+1.
- Each press is exactly HOLD cycles of a nonzero value followed by exactly GAP zero cycles.
- Round r lasts r·(HOLD+GAP) cycles, plus 1 cycle in PROX between rounds.
- Result latency: `ganhou`/`perdeu` sampled at edge n gives `fim`=1 at cycle n+1.
- TMO counting starts in the first AGUARDA cycle. `fim` rises exactly TMO cycles later.
- `db_estado` and `db_rodada` update in the same cycle as the state change.

## Configuration
- Macro `JOGADOR_ERRO_EN`:
  - When defined, adds inputs `erro_en` (1 bit) and `erro_rodada` (4 bits). If `erro_en`=1, the last press of round `erro_rodada`+1 drives `ROM[j] << 1` (rotated left: 1000 becomes 0001) instead of ROM[j]. This deliberately produces a wrong move.
  - When undefined, these ports and the logic behind them are absent, and presses always match the ROM.

## Test plan
- Reset mid-PRESSIONA (`botoes`=0010) → all outputs 0 within the same cycle and `db_estado`=0. After release, no activity until `iniciar`.
- `iniciar` pulse with defaults → `jogar` high exactly 5 cycles. First `botoes`=0001 appears 10 cycles later and is held exactly 10 cycles.
- RODADAS=4 with a behavioural game model → exact sequence 0001 | 0001,0010 | 0001,0010,0100 | 0001,0010,0100,1000, with 10 zero cycles between presses. Model asserts `ganhou` → `fim`=1, `sucesso`=1 one cycle later.
- No response after the last press with TMO=50 → `fim`=1 and `timeout`=1 exactly 50 cycles into AGUARDA.
- `ganhou` and `perdeu` high in the same cycle during round 2 → FIM with `sucesso`=0. `iniciar` in FIM restarts with `jogar`=1 next cycle.
- `JOGADOR_ERRO_EN`, `erro_en`=1, `erro_rodada`=4 → fifth round's last press is 0010 instead of 0001. Model asserts `perdeu` → `sucesso`=0.

Source files
------------

// File: rtl/jogador_automatico_if.sv
// Game-side link between the auto-player and the memory-game core.
//   jogar  : start pulse, player -> core
//   botoes : one-hot button presses, player -> core
//   ganhou : win indication, core -> player
//   perdeu : loss indication, core -> player
// master = player side, slave = game core side.
interface jogador_automatico_if;
  logic       jogar;
  logic [3:0] botoes;
  logic       ganhou;
  logic       perdeu;

  modport master (output jogar, output botoes, input ganhou, input perdeu);
  modport slave  (input jogar, input botoes, output ganhou, output perdeu);
endinterface

// File: rtl/jogador_automatico.sv
// Hardware auto-player for the memory game. It starts a game, then replays the
// one-hot sequence 0001, 0010, 0100, 1000, ... round by round with fixed hold
// and release times. It stops on ganhou/perdeu from the core or when a timeout
// expires after the last press.
//
// Ports:
//   clock_i        : clock, rising edge
//   reset_ni       : asynchronous active-low reset
//   iniciar_i      : start request (level), ignored while busy
//   jogo_io        : game link (jogar/botoes out, ganhou/perdeu in)
//   ocupado_o      : high in every state except OCIOSO and FIM
//   fim_o          : high in FIM
//   sucesso_o      : valid with fim_o, 1 = ganhou seen
//   timeout_o      : valid with fim_o, 1 = wait for result expired
//   db_estado_o    : state code
//   db_rodada_o    : current round minus 1
// Optional feature (macro JOGADOR_ERRO_EN): adds erro_en_i / erro_rodada_i.
// With erro_en_i=1 the last press of round erro_rodada_i+1 is rotated left by
// one bit, producing a deliberately wrong move.
module jogador_automatico #(
  parameter int unsigned JOGAR_CICLOS = 5,
  parameter int unsigned HOLD         = 10,
  parameter int unsigned GAP          = 10,
  parameter int unsigned RODADAS      = 16,
  parameter int unsigned TMO          = 5000
) (
  input  logic                 clock_i,
  input  logic                 reset_ni,
  input  logic                 iniciar_i,
`ifdef JOGADOR_ERRO_EN
  input  logic                 erro_en_i,
  input  logic [3:0]           erro_rodada_i,
`endif
  jogador_automatico_if.master jogo_io,
  output logic                 ocupado_o,
  output logic                 fim_o,
  output logic                 sucesso_o,
  output logic                 timeout_o,
  output logic [3:0]           db_estado_o,
  output logic [3:0]           db_rodada_o
);

  localparam int unsigned TMax1  = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned TMax2  = (TMax1 > JOGAR_CICLOS) ? TMax1 : JOGAR_CICLOS;
  localparam int unsigned TMax   = (TMax2 > TMO) ? TMax2 : TMO;
  // Timer counts down from N-1, so it never holds TMax itself.
  localparam int unsigned TimerW = (TMax > 1) ? $clog2(TMax) : 1;

  typedef logic [TimerW-1:0] timer_t;

  typedef enum logic [2:0] {
    StOcioso    = 3'd0,
    StInicia    = 3'd1,
    StEspera    = 3'd2,
    StPressiona = 3'd3,
    StSolta     = 3'd4,
    StProx      = 3'd5,
    StAguarda   = 3'd6,
    StFim       = 3'd7
  } state_e;

  state_e     state_q, state_d;
  timer_t     timer_q, timer_d;
  logic [3:0] rodada_q, rodada_d;  // round minus 1
  logic [3:0] indice_q, indice_d;  // press index within the round
  logic       sucesso_q, sucesso_d;
  logic       timeout_q, timeout_d;
  logic       jogar_q, jogar_d;
  logic [3:0] botoes_q, botoes_d;
  logic       ocupado_q, ocupado_d;
  logic       fim_q, fim_d;
  logic       tick;

  function automatic logic [3:0] rom(input logic [1:0] j);
    rom = 4'b0001 << j;
  endfunction

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rodada_d  = rodada_q;
    indice_d  = indice_q;
    sucesso_d = sucesso_q;
    timeout_d = timeout_q;
    tick      = (timer_q == '0);

    unique case (state_q)
      StOcioso: begin
        if (iniciar_i) begin
          state_d = StInicia;
          timer_d = timer_t'(JOGAR_CICLOS - 1);
        end
      end
      StInicia: begin
        if (tick) begin
          state_d = StEspera;
          timer_d = timer_t'(GAP - 1);
        end else begin
          timer_d = timer_q - timer_t'(1);
        end
      end
      StEspera: begin
        if (tick) begin
          state_d  = StPressiona;
          rodada_d = '0;
          indice_d = '0;
          timer_d  = timer_t'(HOLD - 1);
        end else begin
          timer_d = timer_q - timer_t'(1);
        end
      end
      StPressiona: begin
        if (tick) begin
          state_d = StSolta;
          timer_d = timer_t'(GAP - 1);
        end else begin
          timer_d = timer_q - timer_t'(1);
        end
      end
      StSolta: begin
        if (tick) begin
          if (indice_q != rodada_q) begin
            indice_d = indice_q + 4'd1;
            state_d  = StPressiona;
            timer_d  = timer_t'(HOLD - 1);
          end else if (rodada_q != 4'(RODADAS - 1)) begin
            state_d = StProx;
          end else begin
            state_d = StAguarda;
            timer_d = timer_t'(TMO - 1);
          end
        end else begin
          timer_d = timer_q - timer_t'(1);
        end
      end
      StProx: begin
        rodada_d = rodada_q + 4'd1;
        indice_d = '0;
        state_d  = StPressiona;
        timer_d  = timer_t'(HOLD - 1);
      end
      StAguarda: begin
        if (tick) begin
          state_d   = StFim;
          timeout_d = 1'b1;
          sucesso_d = 1'b0;
        end else begin
          timer_d = timer_q - timer_t'(1);
        end
      end
      StFim: begin
        if (iniciar_i) begin
          state_d   = StInicia;
          sucesso_d = 1'b0;
          timeout_d = 1'b0;
          rodada_d  = '0;
          indice_d  = '0;
          timer_d   = timer_t'(JOGAR_CICLOS - 1);
        end
      end
    endcase

    // Result from the core overrides sequencing; perdeu has priority.
    if (state_q inside {StInicia, StEspera, StPressiona, StSolta, StProx, StAguarda}) begin
      if (jogo_io.perdeu) begin
        state_d   = StFim;
        sucesso_d = 1'b0;
        timeout_d = 1'b0;
      end else if (jogo_io.ganhou) begin
        state_d   = StFim;
        sucesso_d = 1'b1;
        timeout_d = 1'b0;
      end
    end
  end

  // Outputs are decoded from the next state so they change with the state.
  always_comb begin
    jogar_d   = (state_d == StInicia);
    fim_d     = (state_d == StFim);
    ocupado_d = (state_d != StOcioso) && (state_d != StFim);
    botoes_d  = '0;
    if (state_d == StPressiona) begin
      botoes_d = rom(indice_d[1:0]);
`ifdef JOGADOR_ERRO_EN
      if (erro_en_i && (rodada_d == erro_rodada_i) && (indice_d == rodada_d)) begin
        botoes_d = {botoes_d[2:0], botoes_d[3]};
      end
`endif
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StOcioso;
      timer_q   <= '0;
      rodada_q  <= '0;
      indice_q  <= '0;
      sucesso_q <= 1'b0;
      timeout_q <= 1'b0;
      jogar_q   <= 1'b0;
      botoes_q  <= '0;
      ocupado_q <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rodada_q  <= rodada_d;
      indice_q  <= indice_d;
      sucesso_q <= sucesso_d;
      timeout_q <= timeout_d;
      jogar_q   <= jogar_d;
      botoes_q  <= botoes_d;
      ocupado_q <= ocupado_d;
      fim_q     <= fim_d;
    end
  end

  assign jogo_io.jogar  = jogar_q;
  assign jogo_io.botoes = botoes_q;
  assign ocupado_o      = ocupado_q;
  assign fim_o          = fim_q;
  assign sucesso_o      = sucesso_q;
  assign timeout_o      = timeout_q;
  assign db_estado_o    = {1'b0, state_q};
  assign db_rodada_o    = rodada_q;

endmodule
